// File: rtl/aes_pkg.sv
// Shared AES definitions for the round datapath and key expansion.
//   STATE_W / BYTE_W : state and byte widths
//   BYTE_BIT(r, c)   : LSB index of state byte (row r, column c) in a 128-bit word
//   aes_state_t      : SubBytes/ShiftRows sequencing states
//   SBOX_TABLE       : forward S-box, entry 0x00 in the most significant byte
//   sbox_lookup()    : combinational forward S-box
//   shift_rows()     : ShiftRows on a 128-bit state
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int BYTE_W  = 8;

  // state   | meaning
  // IDLE    | waiting for a start request
  // SUB     | substituting a chunk of bytes per clock
  // DONE    | result presented, success pulse
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } aes_state_t;

  function automatic int BYTE_BIT(input int r, input int c);
    return 32 * c + 8 * r;
  endfunction

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b lives at bit 8*(255-b); for an 8-bit b that is 8*(~b).
  function automatic logic [BYTE_W-1:0] sbox_lookup(input logic [BYTE_W-1:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: BYTE_W];
  endfunction

  // out(r,c) = in(r, (c+r) mod 4)
  function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[BYTE_BIT(r, c) +: BYTE_W] = s[BYTE_BIT(r, (c + r) % 4) +: BYTE_W];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational.
//   din  : input byte
//   dout : S(din)
module aes_sbox
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout
);

  assign dout = sbox_lookup(din);

endmodule

// File: rtl/sub_bytes_shift_rows.sv
// Iterative SubBytes + ShiftRows stage feeding MixColumns.
//   clk            : clock
//   reset          : async active-low reset
//   value          : input state, captured on an accepted start
//   enableSubShift : start request (level)
//   valueOut       : SubBytes+ShiftRows result, held until next completion
//   success        : one-cycle pulse when valueOut is newly valid
//   busy           : high from start acceptance through the success cycle
//
// state   | meaning
// IDLE    | waiting for enableSubShift
// SUB     | BYTES_PER_CYCLE bytes substituted per clock; one extra cycle
//         | with the counter at 16 loads valueOut and moves to DONE
// DONE    | success/busy high; re-accepts a held start on the next edge
module sub_bytes_shift_rows
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] value,
  input  logic               enableSubShift,
  output logic [STATE_W-1:0] valueOut,
  output logic               success,
  output logic               busy
);

  if (BYTES_PER_CYCLE != 4 && BYTES_PER_CYCLE != 16) begin : g_bad_param
    $error("sub_bytes_shift_rows: BYTES_PER_CYCLE must be 4 or 16");
  end

  localparam logic [4:0] CNT_STEP = 5'(BYTES_PER_CYCLE);
  localparam logic [4:0] CNT_LAST = 5'd16;

  aes_state_t         state, state_nxt;
  logic [4:0]         cnt, cnt_nxt;
  logic [STATE_W-1:0] work, work_nxt;
  logic [STATE_W-1:0] vout_nxt;
  logic               success_nxt, busy_nxt;
  logic [3:0]         base;

  logic [BYTE_W-1:0]  sbox_in  [BYTES_PER_CYCLE];
  logic [BYTE_W-1:0]  sbox_out [BYTES_PER_CYCLE];

  // The counter reaches 16 only in the final SUB cycle, where the chunk
  // is not written back, so wrapping the base index to 0 is harmless.
  assign base = cnt[3:0];

  for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_sbox
    assign sbox_in[i] = work[{base + 4'(i), 3'b000} +: BYTE_W];
    aes_sbox u_sbox (
      .din  (sbox_in[i]),
      .dout (sbox_out[i])
    );
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    work_nxt    = work;
    vout_nxt    = valueOut;
    success_nxt = 1'b0;
    busy_nxt    = busy;
    case (state)
      ST_IDLE: begin
        if (enableSubShift) begin
          work_nxt  = value;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = ST_SUB;
        end
      end
      ST_SUB: begin
        if (cnt == CNT_LAST) begin
          vout_nxt    = shift_rows(work);
          success_nxt = 1'b1;
          state_nxt   = ST_DONE;
        end else begin
          for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
            work_nxt[{base + 4'(i), 3'b000} +: BYTE_W] = sbox_out[i];
          end
          cnt_nxt = cnt + CNT_STEP;
        end
      end
      ST_DONE: begin
        if (enableSubShift) begin
          work_nxt  = value;
          cnt_nxt   = '0;
          state_nxt = ST_SUB;
        end else begin
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      work     <= '0;
      valueOut <= '0;
      success  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      work     <= work_nxt;
      valueOut <= vout_nxt;
      success  <= success_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_sub_bytes_shift_rows.sv
// Directed bench for sub_bytes_shift_rows at 4 and 16 bytes per cycle.
module tb_sub_bytes_shift_rows;

  localparam logic [127:0] V_ZERO  = 128'h0;
  localparam logic [127:0] V_FF    = {128{1'b1}};
  localparam logic [127:0] R_ZERO  = 128'h63636363636363636363636363636363;
  localparam logic [127:0] R_FF    = 128'h16161616161616161616161616161616;
  localparam logic [127:0] V_FIPS  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam logic [127:0] R_FIPS  = 128'he598271ef11141b8ae52b4e0305dbfd4;
  localparam logic [127:0] V_IDX   = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] R_IDX   = 128'h2b6f7cfec577d7307bab01f276676b63;

  logic         clk = 1'b0;
  logic         reset;
  logic         en4, en16;
  logic [127:0] val4, val16;
  logic [127:0] out4, out16;
  logic         succ4, succ16, busy4, busy16;

  int pass_cnt = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  sub_bytes_shift_rows #(.BYTES_PER_CYCLE(4)) dut4 (
    .clk            (clk),
    .reset          (reset),
    .value          (val4),
    .enableSubShift (en4),
    .valueOut       (out4),
    .success        (succ4),
    .busy           (busy4)
  );

  sub_bytes_shift_rows #(.BYTES_PER_CYCLE(16)) dut16 (
    .clk            (clk),
    .reset          (reset),
    .value          (val16),
    .enableSubShift (en16),
    .valueOut       (out16),
    .success        (succ16),
    .busy           (busy16)
  );

  // Drives one start pulse and collects timing; all checks are done by callers.
  task automatic run_block(input bit use16, input logic [127:0] v, input logic [127:0] prev,
                           output logic [127:0] got, output int edges, output int busy_pre,
                           output bit held, output bit busy_at, output bit succ_after,
                           output bit busy_after);
    @(negedge clk);
    if (use16) begin en16 = 1'b1; val16 = v; end
    else begin en4 = 1'b1; val4 = v; end
    @(negedge clk);
    en4 = 1'b0; en16 = 1'b0;
    val4 = {$urandom(), $urandom(), $urandom(), $urandom()};
    val16 = {$urandom(), $urandom(), $urandom(), $urandom()};
    edges = 1; busy_pre = 0; held = 1'b1;
    while (!(use16 ? succ16 : succ4) && edges < 20) begin
      if (use16 ? busy16 : busy4) busy_pre++;
      if ((use16 ? out16 : out4) !== prev) held = 1'b0;
      @(negedge clk);
      edges++;
    end
    got = use16 ? out16 : out4;
    busy_at = use16 ? busy16 : busy4;
    @(negedge clk);
    succ_after = use16 ? succ16 : succ4;
    busy_after = use16 ? busy16 : busy4;
  endtask

  task automatic test_reset();
    reset = 1'b0; en4 = 1'b0; en16 = 1'b0; val4 = '0; val16 = '0;
    repeat (3) @(negedge clk);
    check_cnt++; if (out4 !== '0) $display("FAIL reset_out4 got=%h exp=0", out4); else pass_cnt++;
    check_cnt++; if (succ4 !== 1'b0) $display("FAIL reset_succ4 got=%b exp=0", succ4); else pass_cnt++;
    check_cnt++; if (busy4 !== 1'b0) $display("FAIL reset_busy4 got=%b exp=0", busy4); else pass_cnt++;
    check_cnt++; if (out16 !== '0) $display("FAIL reset_out16 got=%h exp=0", out16); else pass_cnt++;
    check_cnt++; if (succ16 !== 1'b0) $display("FAIL reset_succ16 got=%b exp=0", succ16); else pass_cnt++;
    check_cnt++; if (busy16 !== 1'b0) $display("FAIL reset_busy16 got=%b exp=0", busy16); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    logic [127:0] got; int edges, bp; bit held, ba, sa, bafter;
    run_block(1'b0, V_ZERO, '0, got, edges, bp, held, ba, sa, bafter);
    check_cnt++; if (got !== R_ZERO) $display("FAIL zero_value got=%h exp=%h", got, R_ZERO); else pass_cnt++;
    check_cnt++; if (edges != 6) $display("FAIL zero_latency got=%0d exp=6", edges); else pass_cnt++;
    check_cnt++; if (bp != 5) $display("FAIL zero_busy_before got=%0d exp=5", bp); else pass_cnt++;
    check_cnt++; if (ba !== 1'b1) $display("FAIL zero_busy_at_success got=%b exp=1", ba); else pass_cnt++;
    check_cnt++; if (held !== 1'b1) $display("FAIL zero_out_held got=%b exp=1", held); else pass_cnt++;
    check_cnt++; if (sa !== 1'b0 || bafter !== 1'b0)
      $display("FAIL zero_after succ=%b busy=%b exp=0/0", sa, bafter); else pass_cnt++;
  endtask

  task automatic test_fips();
    logic [127:0] got; int edges, bp; bit held, ba, sa, bafter;
    run_block(1'b0, V_FIPS, R_ZERO, got, edges, bp, held, ba, sa, bafter);
    check_cnt++; if (got !== R_FIPS) $display("FAIL fips_value got=%h exp=%h", got, R_FIPS); else pass_cnt++;
    check_cnt++; if (edges != 6) $display("FAIL fips_latency got=%0d exp=6", edges); else pass_cnt++;
    check_cnt++; if (held !== 1'b1) $display("FAIL fips_out_held got=%b exp=1", held); else pass_cnt++;
    check_cnt++; if (sa !== 1'b0) $display("FAIL fips_pulse_width succ_after=%b exp=0", sa); else pass_cnt++;
  endtask

  task automatic test_shift_rows();
    logic [127:0] got; int edges, bp; bit held, ba, sa, bafter;
    run_block(1'b0, V_IDX, R_FIPS, got, edges, bp, held, ba, sa, bafter);
    check_cnt++; if (got !== R_IDX) $display("FAIL shift_rows_value got=%h exp=%h", got, R_IDX); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int results = 0;
    int last_succ = 0;
    int cyc = 0;
    @(negedge clk);
    en4 = 1'b1; val4 = V_ZERO;
    while (results < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (succ4) begin
        if (results[0] == 1'b0) begin
          check_cnt++; if (out4 !== R_ZERO)
            $display("FAIL b2b_value_%0d got=%h exp=%h", results, out4, R_ZERO); else pass_cnt++;
        end else begin
          check_cnt++; if (out4 !== R_FF)
            $display("FAIL b2b_value_%0d got=%h exp=%h", results, out4, R_FF); else pass_cnt++;
        end
        if (results > 0) begin
          check_cnt++; if (cyc - last_succ != 6)
            $display("FAIL b2b_spacing_%0d got=%0d exp=6", results, cyc - last_succ); else pass_cnt++;
        end
        last_succ = cyc;
        results++;
        val4 = results[0] ? V_FF : V_ZERO;
        if (results == 4) en4 = 1'b0;
      end else begin
        val4 = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    check_cnt++; if (results != 4) $display("FAIL b2b_count got=%0d exp=4", results); else pass_cnt++;
    en4 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [127:0] got; int edges, bp; bit held, ba, sa, bafter;
    bit saw = 1'b0;
    @(negedge clk);
    en4 = 1'b1; val4 = V_FIPS;
    @(negedge clk);
    en4 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_cnt++; if (out4 !== '0) $display("FAIL midreset_out got=%h exp=0", out4); else pass_cnt++;
    check_cnt++; if (busy4 !== 1'b0) $display("FAIL midreset_busy got=%b exp=0", busy4); else pass_cnt++;
    check_cnt++; if (succ4 !== 1'b0) $display("FAIL midreset_succ got=%b exp=0", succ4); else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (succ4 || busy4) saw = 1'b1;
    end
    check_cnt++; if (saw !== 1'b0) $display("FAIL midreset_no_success got=%b exp=0", saw); else pass_cnt++;
    run_block(1'b0, V_FIPS, '0, got, edges, bp, held, ba, sa, bafter);
    check_cnt++; if (got !== R_FIPS) $display("FAIL midreset_rerun got=%h exp=%h", got, R_FIPS); else pass_cnt++;
    check_cnt++; if (edges != 6) $display("FAIL midreset_latency got=%0d exp=6", edges); else pass_cnt++;
  endtask

  task automatic test_bpc16();
    logic [127:0] got; int edges, bp; bit held, ba, sa, bafter;
    run_block(1'b1, V_FIPS, '0, got, edges, bp, held, ba, sa, bafter);
    check_cnt++; if (got !== R_FIPS) $display("FAIL bpc16_fips got=%h exp=%h", got, R_FIPS); else pass_cnt++;
    check_cnt++; if (edges != 3) $display("FAIL bpc16_latency got=%0d exp=3", edges); else pass_cnt++;
    check_cnt++; if (bp != 2) $display("FAIL bpc16_busy_before got=%0d exp=2", bp); else pass_cnt++;
    check_cnt++; if (sa !== 1'b0 || bafter !== 1'b0)
      $display("FAIL bpc16_after succ=%b busy=%b exp=0/0", sa, bafter); else pass_cnt++;
    run_block(1'b1, V_IDX, R_FIPS, got, edges, bp, held, ba, sa, bafter);
    check_cnt++; if (got !== R_IDX) $display("FAIL bpc16_shift_rows got=%h exp=%h", got, R_IDX); else pass_cnt++;
    check_cnt++; if (held !== 1'b1) $display("FAIL bpc16_out_held got=%b exp=1", held); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_fips();
    test_shift_rows();
    test_back_to_back();
    test_reset_mid();
    test_bpc16();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
